// File: rtl/shift_sequencer.sv
// Iterative ARM register-specified shifter (LSL/LSR/ASR/ROR) moving at most STEP bits per cycle.
// Optional flush_i input is enabled by defining SHIFT_SEQ_FLUSH_EN.
module shift_sequencer #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef SHIFT_SEQ_FLUSH_EN
  input  logic        flush_i,
`endif
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] data_i,
  input  logic [1:0]  sh_i,
  input  logic [7:0]  amount_i,
  input  logic        carry_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        carry_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShLsr = 2'b01;
  localparam logic [1:0] ShAsr = 2'b10;
  localparam logic [5:0] StepW = 6'(STEP);

  state_e      state_q, state_d;
  logic [31:0] val_q, val_d;
  logic        carry_q, carry_d;
  logic [1:0]  sh_q, sh_d;
  logic [5:0]  cnt_q, cnt_d;

  logic        flush;
  logic [5:0]  n_init;
  logic [5:0]  k;
  logic [5:0]  lsl_idx;
  logic [5:0]  rsh_idx;
  logic [5:0]  rot_back;

`ifdef SHIFT_SEQ_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Clamped remaining count; the clamps alone produce the ARM by-32/over-32 results.
  always_comb begin
    n_init = 6'd0;
    if (amount_i != 8'd0) begin
      unique case (sh_i)
        ShLsl, ShLsr: n_init = (amount_i > 8'd33) ? 6'd33 : amount_i[5:0];
        ShAsr:        n_init = (amount_i > 8'd32) ? 6'd32 : amount_i[5:0];
        default:      n_init = (amount_i[4:0] == 5'd0) ? 6'd32 : {1'b0, amount_i[4:0]};
      endcase
    end
  end

  assign k        = (cnt_q < StepW) ? cnt_q : StepW;
  assign lsl_idx  = 6'd32 - k;
  assign rsh_idx  = k - 6'd1;
  assign rot_back = 6'd32 - k;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    carry_d = carry_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i && !flush) begin
          val_d   = data_i;
          carry_d = carry_i;
          sh_d    = sh_i;
          cnt_d   = n_init;
          state_d = (n_init == 6'd0) ? StDone : StBusy;
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          unique case (sh_q)
            ShLsl: begin
              val_d   = val_q << k;
              carry_d = val_q[lsl_idx[4:0]];
            end
            ShLsr: begin
              val_d   = val_q >> k;
              carry_d = val_q[rsh_idx[4:0]];
            end
            ShAsr: begin
              val_d   = 32'($signed(val_q) >>> k);
              carry_d = val_q[rsh_idx[4:0]];
            end
            default: begin
              val_d   = (val_q >> k) | (val_q << rot_back);
              carry_d = val_q[rsh_idx[4:0]];
            end
          endcase
          cnt_d = cnt_q - k;
          if (cnt_q == k) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (flush || out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      val_q   <= 32'd0;
      carry_q <= 1'b0;
      sh_q    <= 2'b00;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      carry_q <= carry_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign result_o    = val_q;
  assign carry_o     = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (STEP=4); flush cases need SHIFT_SEQ_FLUSH_EN.
module tb_shift_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] data_i = '0;
  logic [1:0]  sh_i = '0;
  logic [7:0]  amount_i = '0;
  logic        carry_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        carry_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  shift_sequencer #(.STEP(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
`ifdef SHIFT_SEQ_FLUSH_EN
    .flush_i     (flush_i),
`endif
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .sh_i        (sh_i),
    .amount_i    (amount_i),
    .carry_i     (carry_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .carry_o     (carry_o),
    .busy_o      (busy_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request, wait for out_valid, check result/carry/latency, then retire it.
  task automatic run_op(input string name, input logic [31:0] d, input logic [1:0] s,
                        input logic [7:0] a, input logic c, input logic [31:0] exp_r,
                        input logic exp_c, input int exp_lat);
    int lat;
    data_i = d; sh_i = s; amount_i = a; carry_i = c; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 60) begin
      tick();
      lat++;
    end
    checks++;
    if (out_valid_o !== 1'b1 || lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d valid=%b, want %0d", name, lat, out_valid_o, exp_lat);
    end
    checks++;
    if (result_o !== exp_r || carry_o !== exp_c) begin
      errors++;
      $display("FAIL %s result: got %h c=%b, want %h c=%b", name, result_o, carry_o, exp_r, exp_c);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s retire: in_ready=%b out_valid=%b, want 1 0", name, in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (result_o !== 32'd0 || carry_o !== 1'b0 || out_valid_o !== 1'b0 ||
        busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: res=%h c=%b ov=%b busy=%b ir=%b, want 0 0 0 0 1",
               result_o, carry_o, out_valid_o, busy_o, in_ready_o);
    end
  endtask

  task automatic test_shifts();
    run_op("lsl4",    32'h0000_0001, 2'b00, 8'd4,   1'b0, 32'h0000_0010, 1'b0, 2);
    run_op("lsr32",   32'h8000_0001, 2'b01, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 9);
    run_op("lsr40",   32'h8000_0001, 2'b01, 8'd40,  1'b1, 32'h0000_0000, 1'b0, 10);
    run_op("asr255",  32'h8000_0000, 2'b10, 8'd255, 1'b0, 32'hFFFF_FFFF, 1'b1, 9);
    run_op("ror4",    32'h0000_00F1, 2'b11, 8'd4,   1'b1, 32'h1000_000F, 1'b0, 2);
    run_op("ror64",   32'h8000_0001, 2'b11, 8'd64,  1'b0, 32'h8000_0001, 1'b1, 9);
    run_op("lsl32",   32'h8000_0001, 2'b00, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 9);
    run_op("lsl1",    32'hFFFF_FFFF, 2'b00, 8'd1,   1'b0, 32'hFFFF_FFFE, 1'b1, 2);
    run_op("lsl5",    32'hFFFF_FFFF, 2'b00, 8'd5,   1'b0, 32'hFFFF_FFE0, 1'b1, 3);
    run_op("asr5",    32'h8000_0000, 2'b10, 8'd5,   1'b1, 32'hFC00_0000, 1'b0, 3);
    run_op("ror33",   32'h0000_0001, 2'b11, 8'd33,  1'b0, 32'h8000_0000, 1'b1, 2);
    run_op("lsr7",    32'h0000_00C0, 2'b01, 8'd7,   1'b0, 32'h0000_0001, 1'b1, 3);
  endtask

  task automatic test_amount_zero();
    for (int s = 0; s < 4; s++) begin
      run_op($sformatf("amt0_sh%0d", s), 32'h1234_5678, 2'(s), 8'd0, 1'b1,
             32'h1234_5678, 1'b1, 1);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    data_i = 32'h0000_000F; sh_i = 2'b00; amount_i = 8'd4; carry_i = 1'b0; in_valid_i = 1'b1;
    tick();
    data_i = 32'hDEAD_BEEF; sh_i = 2'b01; amount_i = 8'd1;
    lat = 1;
    while (!out_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || busy_o !== 1'b1 ||
          result_o !== 32'h0000_00F0 || carry_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: ov=%b ir=%b busy=%b res=%h c=%b, want 1 0 1 000000f0 0",
                 i, out_valid_o, in_ready_o, busy_o, result_o, carry_o);
      end
      tick();
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    in_valid_i = 1'b0;
    checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ir=%b ov=%b busy=%b, want 1 0 0", in_ready_o, out_valid_o, busy_o);
    end
    tick();
    checks++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: ir=%b busy=%b, want 1 0", in_ready_o, busy_o);
    end
  endtask

  task automatic test_reset_mid_busy();
    data_i = 32'h0000_0001; sh_i = 2'b00; amount_i = 8'd20; carry_i = 1'b0; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b1 || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_busy: busy=%b ir=%b, want 1 0", busy_o, in_ready_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: ov=%b ir=%b busy=%b, want 0 1 0", out_valid_o, in_ready_o, busy_o);
    end
    tick();
    rst_i = 1'b0;
    tick();
    run_op("post_rst", 32'h0000_0003, 2'b00, 8'd20, 1'b0, 32'h0030_0000, 1'b0, 6);
  endtask

`ifdef SHIFT_SEQ_FLUSH_EN
  task automatic test_flush();
    bit seen_valid;
    data_i = 32'h0000_0001; sh_i = 2'b00; amount_i = 8'd20; carry_i = 1'b0; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: ov=%b ir=%b busy=%b, want 0 1 0", out_valid_o, in_ready_o, busy_o);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid_o) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_pulse: saw out_valid=1, want none");
    end
    in_valid_i = 1'b1; flush_i = 1'b1;
    tick();
    in_valid_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_block: ir=%b busy=%b, want 1 0", in_ready_o, busy_o);
    end
    run_op("post_flush", 32'h0000_0003, 2'b00, 8'd20, 1'b0, 32'h0030_0000, 1'b0, 6);
  endtask
`endif

  initial begin
    #12;
    test_reset();
    rst_i = 1'b0;
    tick();
    test_reset();
    test_shifts();
    test_amount_zero();
    test_backpressure();
    test_reset_mid_busy();
`ifdef SHIFT_SEQ_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
